// File: rtl/arb_mux_pkg.sv
// arb_mux shared definitions: channel-count limits and a constant log2.
package arb_mux_pkg;

    localparam int ARB_MUX_N_MIN = 2;
    localparam int ARB_MUX_N_MAX = 16;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/arb_mux_if.sv
// Handshake bundle between N producers, the arb_mux and one consumer.
interface arb_mux_if
    import arb_mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 4
);
    localparam int SEL_W = clog2(N);

    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [N*WIDTH-1:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_sel;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );

endinterface

// File: rtl/arb_mux_rr_arbiter.sv
// Combinational round-robin grant starting at ptr.
// ARB_MUX_FIXED_PRIO_EN switches to lowest-index-wins.
module rr_arbiter
    import arb_mux_pkg::*;
#(
    parameter  int N     = 4,
    localparam int SEL_W = clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    int j;

`ifdef ARB_MUX_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;
`endif

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
`ifdef ARB_MUX_FIXED_PRIO_EN
            j = k;
`else
            // explicit wrap keeps non-power-of-2 N correct
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
`endif
            if (!any && req[j]) begin
                any      = 1'b1;
                idx      = SEL_W'(j);
                grant[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arb_mux.sv
// N-channel registered mux with valid/ready on every port.
// ARB_MUX_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int N     = 4,
    localparam int SEL_W = clog2(N)
) (
    input  logic      clk,
    input  logic      reset,
    arb_mux_if.slave  bus
);

    logic [N-1:0]     grant;
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] ptr;
    logic             any;
    logic             load;
    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic [SEL_W-1:0] sel_q;

    rr_arbiter #(.N(N)) u_arb (
        .req   (bus.in_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (idx),
        .any   (any)
    );

    // drain and refill may happen on the same edge
    assign load         = !valid_q || bus.out_ready;
    assign bus.in_ready = (load && any && !reset) ? grant : '0;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_sel   = sel_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sel_q   <= '0;
            ptr     <= '0;
        end else if (load) begin
            if (any) begin
                valid_q <= 1'b1;
                data_q  <= bus.in_data[idx*WIDTH +: WIDTH];
                sel_q   <= idx;
`ifndef ARB_MUX_FIXED_PRIO_EN
                ptr     <= (idx == SEL_W'(N-1)) ? '0 : idx + 1'b1;
`endif
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_arb_mux.sv
// Self-checking bench for arb_mux: vector table, N=3 sequence, random vs model.
module tb_arb_mux;

    logic clk = 1'b0;
    logic reset;
    logic reset3;

    always #5 clk = ~clk;

    arb_mux_if #(.N(4), .WIDTH(4)) b4 ();
    arb_mux_if #(.N(3), .WIDTH(8)) b3 ();

    arb_mux #(.WIDTH(4), .N(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (b4)
    );

    arb_mux #(.WIDTH(8), .N(3)) dut3 (
        .clk   (clk),
        .reset (reset3),
        .bus   (b3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    bit       m_valid;
    bit [3:0] m_data;
    int       m_sel;
    int       m_ptr;

    typedef struct {
        logic        rst;
        logic [3:0]  v;
        logic [15:0] d;
        logic        ordy;
        logic [3:0]  rdy;
        logic        ov;
        logic [3:0]  od;
        logic [1:0]  os;
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // first valid channel in scan order from p
    function automatic int model_grant(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_MUX_FIXED_PRIO_EN
            if (v[k]) return k;
`else
            if (v[(p + k) % 4]) return (p + k) % 4;
`endif
        end
        return -1;
    endfunction

    task automatic tick(input bit use_model, output logic [3:0] rdy_seen);
        int       g;
        bit       ld;
        logic [3:0] er;
        @(negedge clk);
        g  = model_grant(b4.in_valid, m_ptr);
        ld = !m_valid || b4.out_ready;
        er = (!reset && ld && g >= 0) ? 4'(1 << g) : 4'h0;
        rdy_seen = b4.in_ready;
        if (use_model) begin
            chk("in_ready", b4.in_ready, er);
            chk("in_ready_onehot", 32'($onehot0(b4.in_ready)), 1);
        end
        @(posedge clk);
        if (reset) begin
            m_valid = 0; m_data = 0; m_sel = 0; m_ptr = 0;
        end else if (ld) begin
            if (g >= 0) begin
                m_valid = 1;
                m_data  = b4.in_data[g*4 +: 4];
                m_sel   = g;
                m_ptr   = (g + 1) % 4;
            end else begin
                m_valid = 0;
            end
        end
        #1;
        if (use_model) begin
            chk("out_valid", b4.out_valid, m_valid);
            chk("out_data", b4.out_data, m_data);
            chk("out_sel", b4.out_sel, m_sel);
        end
    endtask

    initial begin
        logic [3:0] rdy;
        int exp_sel3;

        tbl[0]  = '{1'b1, 4'hF, 16'h4321, 1'b1, 4'h0, 1'b0, 4'h0, 2'd0};
        tbl[1]  = '{1'b0, 4'hF, 16'h4321, 1'b1, 4'h1, 1'b1, 4'h1, 2'd0};
        tbl[2]  = '{1'b0, 4'hF, 16'h4321, 1'b1, 4'h2, 1'b1, 4'h2, 2'd1};
        tbl[3]  = '{1'b0, 4'hF, 16'h4321, 1'b1, 4'h4, 1'b1, 4'h3, 2'd2};
        tbl[4]  = '{1'b0, 4'hF, 16'h4321, 1'b1, 4'h8, 1'b1, 4'h4, 2'd3};
        tbl[5]  = '{1'b0, 4'hF, 16'h4321, 1'b1, 4'h1, 1'b1, 4'h1, 2'd0};
        tbl[6]  = '{1'b0, 4'h4, 16'h4321, 1'b1, 4'h4, 1'b1, 4'h3, 2'd2};
        tbl[7]  = '{1'b0, 4'h3, 16'h4321, 1'b1, 4'h1, 1'b1, 4'h1, 2'd0};
        tbl[8]  = '{1'b0, 4'h3, 16'h4321, 1'b1, 4'h2, 1'b1, 4'h2, 2'd1};
        tbl[9]  = '{1'b0, 4'h4, 16'h0700, 1'b1, 4'h4, 1'b1, 4'h7, 2'd2};
        tbl[10] = '{1'b0, 4'h4, 16'h0700, 1'b0, 4'h0, 1'b1, 4'h7, 2'd2};
        tbl[11] = '{1'b0, 4'h4, 16'h0700, 1'b0, 4'h0, 1'b1, 4'h7, 2'd2};
        tbl[12] = '{1'b0, 4'h4, 16'h0500, 1'b1, 4'h4, 1'b1, 4'h5, 2'd2};
        tbl[13] = '{1'b0, 4'h0, 16'h0500, 1'b1, 4'h0, 1'b0, 4'h5, 2'd2};
        tbl[14] = '{1'b0, 4'h0, 16'h0500, 1'b0, 4'h0, 1'b0, 4'h5, 2'd2};
        tbl[15] = '{1'b0, 4'h4, 16'h0A00, 1'b1, 4'h4, 1'b1, 4'hA, 2'd2};
        tbl[16] = '{1'b0, 4'h4, 16'h0A00, 1'b0, 4'h0, 1'b1, 4'hA, 2'd2};
        tbl[17] = '{1'b1, 4'hF, 16'h4321, 1'b1, 4'h0, 1'b0, 4'h0, 2'd0};
        tbl[18] = '{1'b0, 4'hA, 16'h4321, 1'b1, 4'h2, 1'b1, 4'h2, 2'd1};

        m_valid = 0; m_data = 0; m_sel = 0; m_ptr = 0;

        // N=3, WIDTH=8 instance: all channels valid, consumer always ready
        reset          = 1'b1;
        b4.in_valid    = '0;
        b4.in_data     = '0;
        b4.out_ready   = 1'b0;
        reset3         = 1'b1;
        b3.in_valid    = 3'b111;
        b3.in_data     = 24'h33_22_11;
        b3.out_ready   = 1'b1;
        @(posedge clk);
        #1;
        reset3 = 1'b0;
        chk("n3_reset_valid", b3.out_valid, 0);
        chk("n3_reset_sel", b3.out_sel, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
`ifdef ARB_MUX_FIXED_PRIO_EN
            exp_sel3 = 0;
`else
            exp_sel3 = i % 3;
`endif
            chk("n3_sel", b3.out_sel, exp_sel3);
            chk("n3_data", b3.out_data, 8'h11 * (exp_sel3 + 1));
            chk("n3_valid", b3.out_valid, 1);
        end

`ifndef ARB_MUX_FIXED_PRIO_EN
        for (int i = 0; i < 19; i++) begin
            reset        = tbl[i].rst;
            b4.in_valid  = tbl[i].v;
            b4.in_data   = tbl[i].d;
            b4.out_ready = tbl[i].ordy;
            tick(1'b0, rdy);
            chk($sformatf("tbl%0d_in_ready", i), rdy, tbl[i].rdy);
            chk($sformatf("tbl%0d_out_valid", i), b4.out_valid, tbl[i].ov);
            chk($sformatf("tbl%0d_out_data", i), b4.out_data, tbl[i].od);
            chk($sformatf("tbl%0d_out_sel", i), b4.out_sel, tbl[i].os);
        end
`else
        reset = 1'b1;
        tick(1'b0, rdy);
`endif

        for (int i = 0; i < 400; i++) begin
            reset        = ($urandom_range(0, 49) == 0);
            b4.in_valid  = 4'($urandom);
            b4.in_data   = 16'($urandom);
            b4.out_ready = ($urandom_range(0, 3) != 0);
            tick(1'b1, rdy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/arb_mux.md
Name: arb_mux

Overview:
Parametrised N-channel, WIDTH-bit registered multiplexer with valid/ready handshake on every input and on the output. It is the successor to the fixed 4:1 combinational mux4. Selection is made by an internal round-robin arbiter instead of an external select, and the winning word is captured in a single output register. Used in the processor datapath wherever several producers share one consumer, e.g. writeback and result buses.

Parameters:
WIDTH, 4, data width per channel in bits
N, 4, number of input channels (2..16)
SEL_W, $clog2(N), width of out_sel (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  N  bit i: channel i presents data
in_ready  output  N  bit i: channel i word accepted this cycle
in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
out_valid  output  1  out_data/out_sel hold a word
out_ready  input  1  consumer accepts the word this cycle
out_data  output  WIDTH  registered selected word
out_sel  output  SEL_W  index of the channel that supplied out_data

Behaviour:
- Reset (reset=1 at a clk edge): out_valid=0, out_data=0, out_sel=0, priority pointer ptr=0. in_ready is all zero while reset=1.
- Reset takes effect mid-transfer: a held, unaccepted word is discarded.
- Define load = !out_valid || out_ready (output register empty, or being drained this cycle).
- Grant (combinational): g is the first i with in_valid[i]=1, scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1. If no channel is valid, there is no grant.
- in_ready[g] = load && grant exists. All other in_ready bits are 0, so at most one bit is set per cycle (one-hot or zero).
- Clock edge with load=1 and a grant:
  - out_data <= in_data[g]
  - out_sel <= g
  - out_valid <= 1
  - ptr <= (g==N-1) ? 0 : g+1. Wrap is explicit, so non-power-of-2 N works.
- Clock edge with load=1 and no grant: out_valid <= 0. out_data, out_sel and ptr hold.
- Clock edge with load=0 (out_valid=1, out_ready=0): out_data, out_sel, out_valid and ptr all hold (stall). All in_ready bits are 0.
- Latency: an input accepted at edge k appears on out_data after edge k.
- Throughput: 1 word/cycle when out_ready stays high. A simultaneous drain and refill in the same cycle must not create a bubble.
- Fairness: a continuously valid channel is granted within N accepted transfers.
- in_valid may drop without handshake; there is no obligation on producers.
- out_data is the exact WIDTH-bit word, with no extension or truncation.

Optional Feature:
ARB_MUX_FIXED_PRIO_EN
- Defined: fixed priority. g is the lowest-index valid channel, ptr is neither used nor updated, and the fairness guarantee is void.
- Undefined (default): round-robin as specified above.
- The port list is identical in both builds.

Decomposition:
- Shared package/header arb_mux_pkg: function clog2, and localparams for the N range limits (ARB_MUX_N_MIN=2, ARB_MUX_N_MAX=16).
- One natural sub-module, rr_arbiter #(N):
  - Inputs: req[N], ptr.
  - Outputs: grant one-hot, grant index, any_grant.
  - Purely combinational; holds the FIXED_PRIO macro switch.
- arb_mux keeps the output register, the pointer register and the handshake logic.

Test Plan:
- Reset mid-stall:
  - Setup: out_valid=1, out_ready=0, out_data=4'hA.
  - Stimulus: assert reset for 1 cycle.
  - Expected: out_valid=0, out_data=0, out_sel=0, in_ready=0. After release, the first grant goes to the lowest-index valid channel (ptr=0).
- Round-robin, all valid:
  - Stimulus: N=4, in_valid=4'b1111, data ch0..3 = 1,2,3,4, out_ready=1.
  - Expected: out_sel sequence 0,1,2,3,0. out_data 1,2,3,4,1 on consecutive cycles with no bubble.
- Pointer skip and wrap:
  - Setup: ptr=3 (after granting ch2).
  - Stimulus: in_valid=4'b0011.
  - Expected: grant ch0, then ch1. Every in_ready vector is one-hot.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles with in_valid=4'b0100, data=4'h7.
  - Expected: one word (7) loaded; in_ready=0 for the remaining stalled cycles; out_data stable. When out_ready=1, the next word is loaded in the same cycle.
- Idle drain:
  - Stimulus: in_valid=0, out_valid=1, out_ready=1.
  - Expected: out_valid=0 next cycle; out_data and out_sel unchanged.
- Non-power-of-2:
  - Stimulus: N=3, WIDTH=8, all valid.
  - Expected: out_sel 0,1,2,0 (never 3). With ARB_MUX_FIXED_PRIO_EN defined, the same stimulus gives out_sel 0,0,0,0.
